fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares one fifo write port among N_REQ producers using round-robin arbitration with bounded bursts.
//  Sits in front of the fifo: drives its wr_en/wr_data and observes its full flag.
//  Returns a per-requester ack for every word actually written.
// PARAMETERS
//  DATA_TYPE   logic[1:0]  word type; matches the fifo's DATA_TYPE
//  N_REQ       4           number of requesters (>=1)
//  MAX_BURST   2           max consecutive writes per grant (>=1)
// PORTS
//  clk          in   1            single clock, all state on posedge
//  reset        in   1            synchronous, active-high
//  req          in   N_REQ        per-requester write request
//  req_data     in   DATA_TYPE[N_REQ]  per-requester write word
//  fifo_full    in   1            fifo full flag
//  grant        out  N_REQ        registered one-hot owner; 0 when idle
//  ack          out  N_REQ        one-hot; word of that requester written this cycle
//  fifo_wr_en   out  1            fifo write enable
//  fifo_wr_data out  DATA_TYPE    fifo write word
//  busy         out  1            grant != 0
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, ack=0, fifo_wr_en=0, fifo_wr_data=0, busy=0, rr_ptr=0, burst_cnt=0.
//  - Reset overrides everything, including a burst in progress.
//  - No write occurs in the reset cycle.
//  Arbitration picks the first asserted req at or after rr_ptr, modulo N_REQ.
//  FSM states:
//  - IDLE:
//    - If any req is asserted, go to OWN next cycle with grant=onehot(winner) and burst_cnt=0.
//    - Latency: req asserted in cycle t gives grant in t+1 and the earliest write in t+1.
//  - OWN:
//    - ack[o] = grant[o] & req[o] & !fifo_full. All other ack bits are 0.
//    - fifo_wr_en = |ack.
//    - fifo_wr_data = req_data[owner] while granted; 0 when idle.
//    - Each ack increments burst_cnt. Counter width is $clog2(MAX_BURST+1).
//  Release happens in the cycle where either:
//  - req[owner] is low (withdraw; no write that cycle), or
//  - the ack that makes burst_cnt reach MAX_BURST occurs.
//  On release:
//  - rr_ptr <= owner+1 mod N_REQ.
//  - Re-arbitrate in the same cycle using the new rr_ptr.
//  - If any req is asserted: next cycle grant = new winner, burst_cnt=0, with no idle bubble.
//  - Otherwise: next cycle state = IDLE.
//  - The old owner can win again only if no other req is asserted.
//  fifo_full high:
//  - ack=0, fifo_wr_en=0, grant held, burst_cnt unchanged.
//  - Stall cycles never count toward MAX_BURST.
//  Requester rules:
//  - Hold req and req_data stable until ack.
//  - Dropping req before ack withdraws the request; no word is lost or duplicated.
//  N_REQ=1: rr_ptr stays 0. The single requester is re-granted after every burst, with no bubble if req is still high.
// TESTING (N_REQ=4, MAX_BURST=2, DATA_TYPE=logic[1:0])
//  1. Reset 2 cycles with req=4'b1111 -> grant, ack, fifo_wr_en, busy all 0. First grant=4'b0001 the cycle after reset drops.
//  2. req=4'b0001, data 2'b01, full=0 from cycle t -> writes in t+1 and t+2. Re-grant 4'b0001 in t+3. Write stream continues with no gap.
//  3. req=4'b1111, full=0 -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001: 2 writes each, round-robin wraps.
//  4. Owner 0001 after 1 write, fifo_full=1 for 3 cycles -> ack=0, wr_en=0, grant=0001 held. Second write occurs when full drops, then release.
//  5. Owner 0001 drops req after 1 ack, req[2] high -> no write that cycle. Next cycle grant=4'b0100.
//  6. Reset mid-burst (grant=0010, burst_cnt=1) -> next cycle grant=0, wr_en=0. Next arbitration starts at requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bus between the requesters/fifo side and the write-port arbiter.
// The slave modport is the arbiter's view; the master modport is the
// producer/fifo side that drives requests and the full flag.
interface fifo_wr_arbiter_if #(
  parameter type DATA_TYPE = logic [1:0],
  parameter int  N_REQ     = 4
);

  logic [N_REQ-1:0] req;
  DATA_TYPE         req_data [N_REQ];
  logic             fifo_full;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] ack;
  logic             fifo_wr_en;
  DATA_TYPE         fifo_wr_data;
  logic             busy;

  modport master (
    output req,
    output req_data,
    output fifo_full,
    input  grant,
    input  ack,
    input  fifo_wr_en,
    input  fifo_wr_data,
    input  busy
  );

  modport slave (
    input  req,
    input  req_data,
    input  fifo_full,
    output grant,
    output ack,
    output fifo_wr_en,
    output fifo_wr_data,
    output busy
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among N_REQ producers.
// A grant lasts until the owner withdraws or has written MAX_BURST words;
// on release the next owner is chosen in the same cycle so there is no
// idle bubble between back-to-back bursts. Cycles where the fifo is full
// neither write nor count toward the burst limit.
module fifo_wr_arbiter #(
  parameter type DATA_TYPE = logic [1:0],
  parameter int  N_REQ     = 4,
  parameter int  MAX_BURST = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  fifo_wr_arbiter_if.slave io_bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    ST_IDLE,
    ST_OWN
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_nextGrant;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_nextOwner;
  logic [IDX_W-1:0] r_rrPtr;
  logic [IDX_W-1:0] w_nextRrPtr;
  logic [CNT_W-1:0] r_burstCnt;
  logic [CNT_W-1:0] w_nextBurstCnt;

  logic [IDX_W-1:0] w_ownerPlusOne;
  logic [IDX_W-1:0] w_arbPtr;
  logic [IDX_W-1:0] w_winner;
  logic             w_anyReq;
  int               w_scanIdx;
  logic [N_REQ-1:0] w_ack;
  logic             w_ownerReq;
  logic             w_burstDone;
  logic             w_release;
  DATA_TYPE         w_wrData;

  // Pointer to the requester just after the current owner, wrapping at N_REQ
  always_comb begin
    w_ownerPlusOne = '0;
    if (int'(r_owner) != N_REQ - 1) begin
      w_ownerPlusOne = r_owner + IDX_W'(1);
    end
  end

  // Search start: stored pointer when idle, owner+1 when releasing a grant
  always_comb begin
    w_arbPtr = r_rrPtr;
    if (r_state == ST_OWN) begin
      w_arbPtr = w_ownerPlusOne;
    end
  end

  // Round-robin pick: first asserted request at or after the search start
  always_comb begin
    w_anyReq  = 1'b0;
    w_winner  = '0;
    w_scanIdx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_scanIdx = int'(w_arbPtr) + i;
      if (w_scanIdx >= N_REQ) begin
        w_scanIdx = w_scanIdx - N_REQ;
      end
      if (!w_anyReq && io_bus.req[IDX_W'(w_scanIdx)]) begin
        w_anyReq = 1'b1;
        w_winner = IDX_W'(w_scanIdx);
      end
    end
  end

  // A word is written only for the owner, while it requests, the fifo has room and not in reset
  always_comb begin
    w_ack = '0;
    if ((r_state == ST_OWN) && !i_reset && !io_bus.fifo_full) begin
      w_ack = r_grant & io_bus.req;
    end
  end

  // Release conditions: owner withdrew, or this write completes the burst
  always_comb begin
    w_ownerReq  = io_bus.req[r_owner];
    w_burstDone = (|w_ack) && (r_burstCnt == BURST_LAST);
    w_release   = (r_state == ST_OWN) && (!w_ownerReq || w_burstDone);
  end

  // State and datapath registers; reset wins over any burst in progress
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rrPtr    <= '0;
      r_burstCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_grant    <= w_nextGrant;
      r_owner    <= w_nextOwner;
      r_rrPtr    <= w_nextRrPtr;
      r_burstCnt <= w_nextBurstCnt;
    end
  end

  // Next-state logic: grant on any request, hand over or go idle on release
  always_comb begin
    w_nextState    = r_state;
    w_nextGrant    = r_grant;
    w_nextOwner    = r_owner;
    w_nextRrPtr    = r_rrPtr;
    w_nextBurstCnt = r_burstCnt;
    case (r_state)
      ST_IDLE: begin
        if (w_anyReq) begin
          w_nextState    = ST_OWN;
          w_nextGrant    = N_REQ'(1) << w_winner;
          w_nextOwner    = w_winner;
          w_nextBurstCnt = '0;
        end
      end
      ST_OWN: begin
        if (w_release) begin
          w_nextRrPtr    = w_ownerPlusOne;
          w_nextBurstCnt = '0;
          if (w_anyReq) begin
            w_nextState = ST_OWN;
            w_nextGrant = N_REQ'(1) << w_winner;
            w_nextOwner = w_winner;
          end else begin
            w_nextState = ST_IDLE;
            w_nextGrant = '0;
            w_nextOwner = '0;
          end
        end else if (|w_ack) begin
          w_nextBurstCnt = r_burstCnt + CNT_W'(1);
        end
      end
      default: begin
        w_nextState    = ST_IDLE;
        w_nextGrant    = '0;
        w_nextOwner    = '0;
        w_nextBurstCnt = '0;
      end
    endcase
  end

  // Output logic: owner's word presented while granted, zero when idle or in reset
  always_comb begin
    w_wrData = '0;
    if ((r_state == ST_OWN) && !i_reset) begin
      w_wrData = io_bus.req_data[r_owner];
    end
  end

  assign io_bus.grant        = r_grant;
  assign io_bus.ack          = w_ack;
  assign io_bus.fifo_wr_en   = |w_ack;
  assign io_bus.fifo_wr_data = w_wrData;
  assign io_bus.busy         = |r_grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=2, 2-bit words).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge and compared against hand-computed expectations.
module tb_fifo_wr_arbiter;

  localparam int N_REQ     = 4;
  localparam int MAX_BURST = 2;
  typedef logic [1:0] data_t;

  logic  clk;
  logic  reset;
  int    compareCount;
  int    mismatchCount;
  data_t wordOf [N_REQ];
  int    ownerSeq [9];

  fifo_wr_arbiter_if #(.DATA_TYPE(data_t), .N_REQ(N_REQ)) bus ();

  fifo_wr_arbiter #(
    .DATA_TYPE(data_t),
    .N_REQ    (N_REQ),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle, drive the inputs for it, then wait for the sample point
  task automatic applyStimulus(input logic rst, input logic [N_REQ-1:0] r, input logic full);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.req       = r;
    bus.fifo_full = full;
    @(negedge clk);
  endtask

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every output of the current cycle
  task automatic checkCycle(input string tag, input logic [N_REQ-1:0] expGrant,
                            input logic [N_REQ-1:0] expAck, input logic expWrEn,
                            input data_t expData);
    checkOutput($sformatf("%s.grant", tag), 32'(bus.grant), 32'(expGrant));
    checkOutput($sformatf("%s.ack", tag), 32'(bus.ack), 32'(expAck));
    checkOutput($sformatf("%s.wr_en", tag), 32'(bus.fifo_wr_en), 32'(expWrEn));
    checkOutput($sformatf("%s.wr_data", tag), 32'(bus.fifo_wr_data), 32'(expData));
    checkOutput($sformatf("%s.busy", tag), 32'(bus.busy), 32'(|expGrant));
  endtask

  initial begin
    logic [N_REQ-1:0] g;
    compareCount  = 0;
    mismatchCount = 0;
    wordOf[0] = 2'b01;
    wordOf[1] = 2'b10;
    wordOf[2] = 2'b11;
    wordOf[3] = 2'b00;
    ownerSeq  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_data[i] = wordOf[i];
    end
    reset         = 1'b1;
    bus.req       = 4'b1111;
    bus.fifo_full = 1'b0;

    // Reset held two cycles with every requester asking
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkCycle("rst0", 4'b0000, 4'b0000, 1'b0, 2'b00);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkCycle("rst1", 4'b0000, 4'b0000, 1'b0, 2'b00);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkCycle("rstDrop", 4'b0000, 4'b0000, 1'b0, 2'b00);

    // All requesting: two writes each, wrapping back to requester 0
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0);
      g = 4'b0001 << ownerSeq[i];
      checkCycle($sformatf("rr%0d", i), g, g, 1'b1, wordOf[ownerSeq[i]]);
    end

    // Owner 0 has one write done; fifo full stalls for three cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkCycle($sformatf("full%0d", i), 4'b0001, 4'b0000, 1'b0, 2'b01);
    end
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkCycle("fullDrop", 4'b0001, 4'b0001, 1'b1, 2'b01);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkCycle("afterFull", 4'b0010, 4'b0010, 1'b1, 2'b10);

    // Reset in the middle of requester 1's burst
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkCycle("midRst", 4'b0010, 4'b0000, 1'b0, 2'b00);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkCycle("postRst", 4'b0000, 4'b0000, 1'b0, 2'b00);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkCycle("rstRegrant", 4'b0001, 4'b0001, 1'b1, 2'b01);

    // Owner 0 withdraws after one write while requester 2 waits
    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkCycle("withdraw", 4'b0001, 4'b0000, 1'b0, 2'b01);
    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkCycle("toReq2", 4'b0100, 4'b0100, 1'b1, 2'b11);

    // Single requester: continuous write stream across re-grants
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkCycle("soloT0", 4'b0100, 4'b0000, 1'b0, 2'b11);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 4'b0001, 1'b0);
      checkCycle($sformatf("soloT%0d", i), 4'b0001, 4'b0001, 1'b1, 2'b01);
    end

    // Everyone drops: owner released and arbiter goes idle
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkCycle("dropAll", 4'b0001, 4'b0000, 1'b0, 2'b01);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkCycle("idle", 4'b0000, 4'b0000, 1'b0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
